// File: rtl/pipeline_debug_ctrl_pkg.sv
// rtl/pipeline_debug_ctrl_pkg.sv - shared types and constants for the pipeline debug controller
package pipeline_debug_ctrl_pkg;

   // Run-control FSM encoding; also reported in the status read-out word
   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   // Status word layout, LSB first: halted, bp_hit, bp_hit_idx, state
   localparam int STAT_HALTED_BIT = 0;
   localparam int STAT_BP_HIT_BIT = 1;
   localparam int STAT_IDX_LSB    = 2;

   // Read-out words that follow the probe channels and breakpoint registers
   localparam int RO_STATUS_OFS = 0;
   localparam int RO_CYCLE_OFS  = 1;

   // Index width that stays at least one bit for single-entry tables
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pipeline_debug_ctrl_if.sv
// rtl/pipeline_debug_ctrl_if.sv - breakpoint write and probe read-out bus
interface pipeline_debug_ctrl_if
   import pipeline_debug_ctrl_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int NUM_BP     = 4,
   parameter int DBG_ADDR_W = 7
);
   localparam int IDX_W = idx_width(NUM_BP);

   logic                  bp_wen;
   logic [IDX_W-1:0]      bp_idx;
   logic [DATA_W-1:0]     bp_addr;
   logic                  bp_valid;
   logic [DBG_ADDR_W-1:0] debug_addr;
   logic [DATA_W-1:0]     debug_data;

   modport master (
      output bp_wen, bp_idx, bp_addr, bp_valid, debug_addr,
      input  debug_data
   );

   modport slave (
      input  bp_wen, bp_idx, bp_addr, bp_valid, debug_addr,
      output debug_data
   );

endinterface

// File: rtl/pipeline_debug_ctrl_sync_edge_det.sv
// rtl/pipeline_debug_ctrl_sync_edge_det.sv - multi-flop synchroniser with optional rising-edge output
module sync_edge_det #(
   parameter int STAGES    = 2,
   parameter bit RISE_EDGE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] chain;

   // Shift the asynchronous input through the metastability chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
      end
   end

   if (RISE_EDGE) begin : g_rise
      logic prev;

      // One extra flop holds the previous synchronised level for edge detection
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            prev <= 1'b0;
         end else begin
            prev <= chain[STAGES-1];
         end
      end

      assign dout = chain[STAGES-1] & ~prev;
   end else begin : g_level
      assign dout = chain[STAGES-1];
   end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// rtl/pipeline_debug_ctrl.sv - single-clock run/halt/step controller with PC breakpoints and probe read-out
module pipeline_debug_ctrl
   import pipeline_debug_ctrl_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int NUM_BP      = 4,
   parameter int STEP_CNT_W  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int NUM_DBG_CH  = 32,
   parameter int DBG_ADDR_W  = 7,
   localparam int IDX_W      = idx_width(NUM_BP)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         debug_en,
   input  logic                         debug_step,
   input  logic [STEP_CNT_W-1:0]        step_count,
   input  logic [DATA_W-1:0]            if_pc,
   input  logic [NUM_DBG_CH*DATA_W-1:0] probe_bus,
   pipeline_debug_ctrl_if.slave         dbg,
   output logic                         cpu_en,
   output logic                         halted,
   output logic                         bp_hit,
   output logic [IDX_W-1:0]             bp_hit_idx,
   output logic [31:0]                  cycle_count
);

   localparam int CH_W = idx_width(NUM_DBG_CH);
   localparam int ST_W = STAT_IDX_LSB + IDX_W + 2;

   state_t                  state;
   logic [STEP_CNT_W-1:0]   remaining;
   logic                    skip_bp;
   logic                    en_s;
   logic                    step_edge;

   logic [DATA_W-1:0]       bp_addr_r [NUM_BP];
   logic [NUM_BP-1:0]       bp_valid_r;
   logic                    hit_any;
   logic [IDX_W-1:0]        hit_idx;
   logic                    bp_match;

   logic [DATA_W-1:0]       probe_ch [NUM_DBG_CH];
   logic [31:0]             addr_ext;
   logic [IDX_W-1:0]        bp_sel;
   logic [ST_W-1:0]         status;
   logic [DATA_W-1:0]       rd_data;

   sync_edge_det #(.STAGES(SYNC_STAGES), .RISE_EDGE(1'b0)) u_sync_en (
      .clk  (clk),
      .rst  (rst),
      .din  (debug_en),
      .dout (en_s)
   );

   sync_edge_det #(.STAGES(SYNC_STAGES), .RISE_EDGE(1'b1)) u_sync_step (
      .clk  (clk),
      .rst  (rst),
      .din  (debug_step),
      .dout (step_edge)
   );

   // Lowest-index valid breakpoint equal to the current IF PC
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (bp_valid_r[i] && (bp_addr_r[i] == if_pc)) begin
            hit_any = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Suppressed for the first enabled cycle after a resume so we can leave the breakpoint PC
   assign bp_match = hit_any & ~skip_bp;

   // Enable is gated in the same cycle as the match so the breakpoint instruction is not fetched
   always_comb begin
      cpu_en = 1'b0;
      case (state)
         ST_RUN:  cpu_en = ~bp_match;
         ST_STEP: cpu_en = 1'b1;
         default: cpu_en = 1'b0;
      endcase
   end

   assign halted = (state == ST_HALT);

   // Run-control FSM: halt/run from the debug switch, bounded step bursts, breakpoint stops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_HALT;
         remaining  <= '0;
         skip_bp    <= 1'b0;
         bp_hit     <= 1'b0;
         bp_hit_idx <= '0;
      end else begin
         if (cpu_en) begin
            skip_bp <= 1'b0;
         end
         case (state)
            ST_HALT: begin
               if (!en_s) begin
                  state   <= ST_RUN;
                  bp_hit  <= 1'b0;
                  skip_bp <= 1'b1;
               end else if (step_edge) begin
                  state     <= ST_STEP;
                  remaining <= (step_count == '0) ? STEP_CNT_W'(1) : step_count;
                  skip_bp   <= 1'b1;
               end
            end
            ST_RUN: begin
               if (bp_match) begin
                  state      <= ST_HALT;
                  bp_hit     <= 1'b1;
                  bp_hit_idx <= hit_idx;
               end else if (en_s) begin
                  state <= ST_HALT;
               end
            end
            ST_STEP: begin
               remaining <= remaining - STEP_CNT_W'(1);
               if (remaining == STEP_CNT_W'(1)) begin
                  state <= ST_HALT;
               end
            end
            default: state <= ST_HALT;
         endcase
      end
   end

   // Breakpoint register file; writes land at the edge so a same-cycle match sees old contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_BP; i++) begin
            bp_addr_r[i] <= '0;
         end
         bp_valid_r <= '0;
      end else if (dbg.bp_wen && (int'(dbg.bp_idx) < NUM_BP)) begin
         bp_addr_r[dbg.bp_idx]  <= dbg.bp_addr;
         bp_valid_r[dbg.bp_idx] <= dbg.bp_valid;
      end
   end

   // Free-running count of enabled pipeline cycles, wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_count <= '0;
      end else if (cpu_en) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end

   for (genvar g = 0; g < NUM_DBG_CH; g++) begin : g_probe
      assign probe_ch[g] = probe_bus[g*DATA_W +: DATA_W];
   end

   assign addr_ext = 32'(dbg.debug_addr);
   assign bp_sel   = IDX_W'(addr_ext - NUM_DBG_CH);

   // Pack the status word from the documented bit positions
   always_comb begin
      status = '0;
      status[STAT_HALTED_BIT]            = halted;
      status[STAT_BP_HIT_BIT]            = bp_hit;
      status[STAT_IDX_LSB +: IDX_W]      = bp_hit_idx;
      status[STAT_IDX_LSB + IDX_W +: 2]  = state;
   end

   // Read-out address decode: probes, breakpoints, status, cycle counter, else all ones
   always_comb begin
      rd_data = DATA_W'(32'hFFFF_FFFF);
      if (addr_ext < NUM_DBG_CH) begin
         rd_data = probe_ch[addr_ext[CH_W-1:0]];
      end else if (addr_ext < NUM_DBG_CH + NUM_BP) begin
         rd_data = bp_addr_r[bp_sel];
      end else if (addr_ext == NUM_DBG_CH + NUM_BP + RO_STATUS_OFS) begin
         rd_data = DATA_W'(status);
      end else if (addr_ext == NUM_DBG_CH + NUM_BP + RO_CYCLE_OFS) begin
         rd_data = DATA_W'(cycle_count);
      end
   end

   // Registered read-out gives one cycle of latency from debug_addr
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg.debug_data <= '0;
      end else begin
         dbg.debug_data <= rd_data;
      end
   end

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// tb/tb_pipeline_debug_ctrl.sv - self-checking bench for pipeline_debug_ctrl
module tb_pipeline_debug_ctrl;
   import pipeline_debug_ctrl_pkg::*;

   localparam int DW   = 32;
   localparam int NBP  = 4;
   localparam int SCW  = 16;
   localparam int SYNC = 2;
   localparam int NCH  = 32;
   localparam int AW   = 7;

   logic              clk;
   logic              rst;
   logic              debug_en;
   logic              debug_step;
   logic [SCW-1:0]    step_count;
   logic [DW-1:0]     if_pc;
   logic [NCH*DW-1:0] probe_bus;
   logic              cpu_en;
   logic              halted;
   logic              bp_hit;
   logic [1:0]        bp_hit_idx;
   logic [31:0]       cycle_count;

   pipeline_debug_ctrl_if #(.DATA_W(DW), .NUM_BP(NBP), .DBG_ADDR_W(AW)) dbg_if ();

   pipeline_debug_ctrl #(
      .DATA_W(DW), .NUM_BP(NBP), .STEP_CNT_W(SCW),
      .SYNC_STAGES(SYNC), .NUM_DBG_CH(NCH), .DBG_ADDR_W(AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .debug_en    (debug_en),
      .debug_step  (debug_step),
      .step_count  (step_count),
      .if_pc       (if_pc),
      .probe_bus   (probe_bus),
      .dbg         (dbg_if),
      .cpu_en      (cpu_en),
      .halted      (halted),
      .bp_hit      (bp_hit),
      .bp_hit_idx  (bp_hit_idx),
      .cycle_count (cycle_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bp_write(input int idx, input logic [31:0] addr, input logic valid);
      dbg_if.bp_wen   = 1'b1;
      dbg_if.bp_idx   = 2'(idx);
      dbg_if.bp_addr  = addr;
      dbg_if.bp_valid = valid;
      tick();
      dbg_if.bp_wen   = 1'b0;
   endtask

   // ---------------- reference model state ----------------
   int          m_mode;      // 0 halted, 1 running, 2 stepping
   int          m_left;
   bit          m_skip;
   bit          m_hit;
   int          m_idx;
   logic [31:0] m_cyc;
   logic [31:0] m_dd;
   logic [31:0] m_bpa [NBP];
   bit          m_bpv [NBP];
   bit          en_d [SYNC];
   bit          st_d [SYNC+1];

   function automatic logic [1:0] m_state_bits();
      case (m_mode)
         1:       return ST_RUN;
         2:       return ST_STEP;
         default: return ST_HALT;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input int a);
      if (a < NCH) return probe_bus[a*DW +: DW];
      if (a < NCH + NBP) return m_bpa[a-NCH];
      if (a == NCH + NBP) return {26'd0, m_state_bits(), 2'(m_idx), m_hit, (m_mode == 0)};
      if (a == NCH + NBP + 1) return m_cyc;
      return 32'hFFFF_FFFF;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_left = 0; m_skip = 0; m_hit = 0; m_idx = 0;
      m_cyc = '0; m_dd = '0;
      for (int i = 0; i < NBP; i++) begin m_bpa[i] = '0; m_bpv[i] = 0; end
      for (int i = 0; i < SYNC; i++) en_d[i] = 0;
      for (int i = 0; i <= SYNC; i++) st_d[i] = 0;
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   exp;
      string         name;
   } rd_vec_t;

   rd_vec_t tbl [9];

   int ones;
   int first;

   initial begin
      tbl[0] = '{7'd0,   32'hA500_0000, "rd_ch0"};
      tbl[1] = '{7'd5,   32'hA500_0005, "rd_ch5"};
      tbl[2] = '{7'd31,  32'hA500_001F, "rd_ch31"};
      tbl[3] = '{7'd32,  32'h0000_1000, "rd_bp0"};
      tbl[4] = '{7'd35,  32'h0000_100C, "rd_bp3"};
      tbl[5] = '{7'd36,  32'h0000_0001, "rd_status"};
      tbl[6] = '{7'd37,  32'h0000_0002, "rd_cycles"};
      tbl[7] = '{7'd38,  32'hFFFF_FFFF, "rd_unmapped38"};
      tbl[8] = '{7'h7F,  32'hFFFF_FFFF, "rd_unmapped7f"};

      rst = 1'b1; debug_en = 1'b1; debug_step = 1'b0; step_count = '0;
      if_pc = 32'h0; probe_bus = '0;
      dbg_if.bp_wen = 1'b0; dbg_if.bp_idx = '0; dbg_if.bp_addr = '0;
      dbg_if.bp_valid = 1'b0; dbg_if.debug_addr = '0;

      // ---- reset state ----
      tick(); tick();
      check("rst_cpu_en", cpu_en, 0);
      check("rst_halted", halted, 1);
      check("rst_bp_hit", bp_hit, 0);
      check("rst_bp_idx", bp_hit_idx, 0);
      check("rst_cycles", cycle_count, 0);
      check("rst_debug_data", dbg_if.debug_data, 0);
      rst = 1'b0;

      // Synchroniser outputs 0 just after reset, so the first edge enters RUN
      tick();
      check("post_rst_run", halted, 0);
      check("post_rst_cpu_en", cpu_en, 1);
      tick();
      check("post_rst_cnt1", cycle_count, 1);
      tick();
      check("post_rst_halt", halted, 1);
      check("post_rst_cnt2", cycle_count, 2);

      // ---- read-out map table ----
      for (int c = 0; c < NCH; c++) probe_bus[c*DW +: DW] = 32'hA500_0000 + 32'(c);
      for (int i = 0; i < NBP; i++) bp_write(i, 32'h1000 + 32'(4*i), 1'b0);
      foreach (tbl[k]) begin
         dbg_if.debug_addr = tbl[k].addr;
         tick();
         check(tbl[k].name, dbg_if.debug_data, tbl[k].exp);
      end

      // ---- run, then stop on a breakpoint ----
      bp_write(0, 32'h10, 1'b1);
      if_pc = 32'h0C;
      debug_en = 1'b0;
      tick(); tick(); tick();
      check("run_halted", halted, 0);
      check("run_cpu_en", cpu_en, 1);
      check("run_cnt", cycle_count, 2);
      tick();
      check("run_cnt_inc", cycle_count, 3);
      debug_en = 1'b1;
      tick();
      check("run_cnt_inc2", cycle_count, 4);
      if_pc = 32'h10;
      #1;
      check("bp_gate_same_cycle", cpu_en, 0);
      tick();
      check("bp_halted", halted, 1);
      check("bp_hit", bp_hit, 1);
      check("bp_hit_idx", bp_hit_idx, 0);
      check("bp_cnt_frozen", cycle_count, 4);
      tick(); tick();
      check("bp_hit_sticky", bp_hit, 1);
      check("bp_still_halted", halted, 1);

      // ---- resume past the breakpoint ----
      debug_en = 1'b0;
      tick(); tick(); tick();
      check("resume_run", halted, 0);
      check("resume_bp_hit_clr", bp_hit, 0);
      check("resume_no_rehit", cpu_en, 1);
      tick();
      if_pc = 32'h14;
      #1;
      check("resume_cnt", cycle_count, 5);
      check("resume_cpu_en", cpu_en, 1);

      // ---- halt, then a 3-cycle burst with a second press during it ----
      debug_en = 1'b1;
      tick(); tick(); tick(); tick();
      check("halt_again", halted, 1);
      check("halt_cnt", cycle_count, 8);
      step_count = 16'd3;
      debug_step = 1'b1;
      ones = 0; first = 0;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (i == 1) debug_step = 1'b0;
         if (i == 2) debug_step = 1'b1;
         if (i == 3) debug_step = 1'b0;
         if (cpu_en) begin
            ones++;
            if (first == 0) first = i;
         end
      end
      check("step3_cycles", ones, 3);
      check("step3_latency", first, SYNC + 1);
      check("step3_cnt", cycle_count, 11);
      check("step3_halted", halted, 1);

      // ---- step_count of zero runs one cycle ----
      step_count = 16'd0;
      debug_step = 1'b1;
      ones = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 1) debug_step = 1'b0;
         if (cpu_en) ones++;
      end
      check("step0_cycles", ones, 1);
      check("step0_cnt", cycle_count, 12);

      // ---- reset in the middle of a burst ----
      step_count = 16'd8;
      debug_step = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 1) debug_step = 1'b0;
      end
      check("burst_active", cpu_en, 1);
      rst = 1'b1;
      #1;
      check("midrst_cpu_en", cpu_en, 0);
      check("midrst_cycles", cycle_count, 0);
      check("midrst_halted", halted, 1);
      dbg_if.debug_addr = 7'd32;
      if_pc = 32'h10;
      tick();
      rst = 1'b0;
      tick();
      check("midrst_bp0_cleared", dbg_if.debug_data, 0);
      tick(); tick();
      check("midrst_no_bp_hit", bp_hit, 0);
      check("midrst_settle_cnt", cycle_count, 2);

      // ---- randomized run against the reference model ----
      rst = 1'b1;
      debug_en = 1'b1; debug_step = 1'b0;
      tick();
      rst = 1'b0;
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        m_match;
         int          m_mi;
         bit          m_cpu;
         bit          es;
         bit          se;
         logic [31:0] pcs [5];

         pcs[0] = 32'h10; pcs[1] = 32'h14; pcs[2] = 32'h18; pcs[3] = 32'h1C; pcs[4] = 32'h20;
         if ($urandom_range(0, 39) == 0) debug_en = ~debug_en;
         if ($urandom_range(0, 5) == 0) debug_step = ~debug_step;
         step_count = 16'($urandom_range(0, 5));
         if_pc = pcs[$urandom_range(0, 4)];
         for (int c = 0; c < NCH; c++) probe_bus[c*DW +: DW] = $urandom();
         dbg_if.bp_wen   = ($urandom_range(0, 9) == 0);
         dbg_if.bp_idx   = 2'($urandom_range(0, NBP-1));
         dbg_if.bp_addr  = pcs[$urandom_range(0, 4)];
         dbg_if.bp_valid = 1'($urandom_range(0, 1));
         dbg_if.debug_addr = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(30, 40))
                                                         : 7'($urandom_range(0, 127));

         @(negedge clk);
         m_match = 1'b0; m_mi = 0;
         for (int i = NBP - 1; i >= 0; i--) begin
            if (m_bpv[i] && m_bpa[i] == if_pc) begin m_match = 1'b1; m_mi = i; end
         end
         if (m_skip) m_match = 1'b0;
         m_cpu = (m_mode == 1) ? !m_match : (m_mode == 2);

         check("rand_cpu_en", cpu_en, m_cpu);
         check("rand_halted", halted, (m_mode == 0));
         check("rand_bp_hit", bp_hit, m_hit);
         check("rand_bp_idx", bp_hit_idx, m_idx);
         check("rand_cycles", cycle_count, m_cyc);
         check("rand_debug_data", dbg_if.debug_data, m_dd);
         if (n_bad > 40) break;

         es = en_d[SYNC-1];
         se = st_d[SYNC-1] && !st_d[SYNC];
         m_dd = m_read(int'(dbg_if.debug_addr));
         if (m_cpu) begin
            m_cyc = m_cyc + 1;
            m_skip = 0;
         end
         if (m_mode == 0) begin
            if (!es) begin
               m_mode = 1; m_hit = 0; m_skip = 1;
            end else if (se) begin
               m_mode = 2; m_left = (step_count == 0) ? 1 : int'(step_count); m_skip = 1;
            end
         end else if (m_mode == 1) begin
            if (m_match) begin
               m_mode = 0; m_hit = 1; m_idx = m_mi;
            end else if (es) begin
               m_mode = 0;
            end
         end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 0;
         end
         if (dbg_if.bp_wen) begin
            m_bpa[dbg_if.bp_idx] = dbg_if.bp_addr;
            m_bpv[dbg_if.bp_idx] = dbg_if.bp_valid;
         end
         for (int j = SYNC - 1; j > 0; j--) en_d[j] = en_d[j-1];
         en_d[0] = debug_en;
         for (int j = SYNC; j > 0; j--) st_d[j] = st_d[j-1];
         st_d[0] = debug_step;

         @(posedge clk);
         #1;
      end
      dbg_if.bp_wen = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
